// File: rtl/overlay_sched.sv
// Fixed-priority overlay sequencer: death > level > piece, each held then blanked; game_over overrides everything.
// Define OVLY_PENDING_EN to queue events that arrive while busy; otherwise they are dropped.
module overlay_sched #(
  parameter int unsigned HOLD_CYCLES  = 8000000,
  parameter int unsigned GAP_CYCLES   = 1000000,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       e_piece,
  input  logic       e_level,
  input  logic       e_death,
  input  logic       game_over,
  input  logic       clr,
  input  logic       mode_arcade,
  input  logic       frame_start,
  output logic [2:0] overlay_sel,
  output logic       flash_on,
  output logic       busy,
  output logic [2:0] pending
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP, GOVER} state_t;

  localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] GAP_LAST   = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);
  localparam logic [31:0] FLASH_LAST = 32'(FLASH_FRAMES - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] frame_q, frame_d;
  logic [2:0]  sel_q, sel_d;
  logic        flash_q, flash_d;
  logic        busy_q, busy_d;
  logic [2:0]  pend_q, pend_d;

  logic [2:0]  ev, req, gmask, gcode;

  // Bit order everywhere is {death, level, piece}; piece only counts in arcade mode.
  always_comb begin
    ev    = {e_death, e_level, e_piece & mode_arcade};
    req   = (pend_q | ev) & {2'b11, mode_arcade};
    gmask = 3'b000;
    gcode = 3'd0;
    if (req[2]) begin
      gmask = 3'b100;
      gcode = 3'd3;
    end else if (req[1]) begin
      gmask = 3'b010;
      gcode = 3'd2;
    end else if (req[0]) begin
      gmask = 3'b001;
      gcode = 3'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    sel_d   = sel_q;
    flash_d = flash_q;
`ifdef OVLY_PENDING_EN
    pend_d  = pend_q | ev;
`else
    pend_d  = 3'b000;
`endif
    if (game_over) begin
      state_d = GOVER;
      sel_d   = 3'd4;
      flash_d = 1'b1;
      cnt_d   = '0;
      frame_d = '0;
      pend_d  = 3'b000;
    end else if (state_q == GOVER || clr) begin
      state_d = IDLE;
      sel_d   = 3'd0;
      flash_d = 1'b0;
      cnt_d   = '0;
      frame_d = '0;
      pend_d  = 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_d = SHOW;
            sel_d   = gcode;
            flash_d = 1'b1;
            cnt_d   = '0;
            frame_d = '0;
`ifdef OVLY_PENDING_EN
            // A fresh pulse only re-arms the winner if the winner was already a stored request.
            pend_d  = (pend_q & ~gmask) | (ev & ~(gmask & ~pend_q));
`endif
          end
        end
        SHOW: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            cnt_d   = '0;
            frame_d = '0;
            sel_d   = 3'd0;
            flash_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 32'd1;
            if (frame_start) begin
              if (frame_q == FLASH_LAST) begin
                flash_d = ~flash_q;
                frame_d = '0;
              end else begin
                frame_d = frame_q + 32'd1;
              end
            end
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
    if (!mode_arcade) pend_d[0] = 1'b0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      sel_q   <= 3'd0;
      flash_q <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      sel_q   <= sel_d;
      flash_q <= flash_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
    end
  end

  assign overlay_sel = sel_q;
  assign flash_on    = flash_q;
  assign busy        = busy_q;
  assign pending     = pend_q;

endmodule

// File: tb/tb_overlay_sched.sv
// Scoreboard bench for overlay_sched with HOLD=10, GAP=3, FLASH_FRAMES=2.
module tb_overlay_sched;

`ifdef OVLY_PENDING_EN
  localparam bit PEND_EN = 1'b1;
`else
  localparam bit PEND_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic e_piece = 0, e_level = 0, e_death = 0, game_over = 0, clr = 0;
  logic mode_arcade = 1, frame_start = 0;
  logic [2:0] overlay_sel, pending;
  logic flash_on, busy;

  logic nx_rst = 0, nx_go = 0, nx_clr = 0, nx_arc = 1;
  int tst = 0;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    int         tst;
    logic [2:0] sel;
    logic       flash;
    logic       busy;
    logic [2:0] pend;
  } exp_t;
  exp_t sb_q[$];

  overlay_sched #(.HOLD_CYCLES(10), .GAP_CYCLES(3), .FLASH_FRAMES(2)) dut (
    .clk(clk), .reset(rst_n), .e_piece(e_piece), .e_level(e_level), .e_death(e_death),
    .game_over(game_over), .clr(clr), .mode_arcade(mode_arcade), .frame_start(frame_start),
    .overlay_sel(overlay_sel), .flash_on(flash_on), .busy(busy), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string f, input int t, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL t%0d %s: actual=%0d expected=%0d (time %0t)", t, f, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per clock edge (or async reset assertion) once outputs settle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("overlay_sel", e.tst, 32'(overlay_sel), 32'(e.sel));
        chk("flash_on",    e.tst, 32'(flash_on),    32'(e.flash));
        chk("busy",        e.tst, 32'(busy),        32'(e.busy));
        chk("pending",     e.tst, 32'(pending),     32'(e.pend));
      end
    end
  end

  function automatic exp_t mk(input logic [2:0] sel, input logic fl, input logic bz, input logic [2:0] pd);
    exp_t e;
    e.tst   = tst;
    e.sel   = sel;
    e.flash = fl;
    e.busy  = bz;
    e.pend  = PEND_EN ? pd : 3'b000;
    return e;
  endfunction

  // One cycle: drive inputs at the falling edge, queue the state expected after the next rising edge.
  task automatic cyc(input logic [2:0] ev, input logic fs, input logic [2:0] sel,
                     input logic fl, input logic bz, input logic [2:0] pd);
    @(negedge clk);
    rst_n = nx_rst; game_over = nx_go; clr = nx_clr; mode_arcade = nx_arc;
    e_death = ev[2]; e_level = ev[1]; e_piece = ev[0]; frame_start = fs;
    sb_q.push_back(mk(sel, fl, bz, pd));
  endtask

  task automatic show(input logic [2:0] code, input logic [2:0] pd, input int n);
    for (int i = 0; i < n; i++) cyc(3'b000, 1'b0, code, 1'b1, 1'b1, pd);
  endtask

  task automatic gap(input logic [2:0] pd);
    for (int i = 0; i < 3; i++) cyc(3'b000, 1'b0, 3'd0, 1'b0, 1'b1, pd);
  endtask

  task automatic idle(input logic [2:0] pd, input int n);
    for (int i = 0; i < n; i++) cyc(3'b000, 1'b0, 3'd0, 1'b0, 1'b0, pd);
  endtask

  task automatic areset();
    @(negedge clk);
    e_death = 0; e_level = 0; e_piece = 0; frame_start = 0;
    sb_q.push_back(mk(3'd0, 1'b0, 1'b0, 3'b000));
    #2;
    nx_rst = 1'b0;
    rst_n  = 1'b0;
  endtask

  initial begin
    logic [8:0] fs_pat;
    logic [8:0] fl_pat;
    // reset state
    tst = 0; idle(3'b000, 3);
    nx_rst = 1; idle(3'b000, 2);

    // single level event: 10 shown, 3 gap, then idle
    tst = 1;
    cyc(3'b010, 1'b0, 3'd2, 1'b1, 1'b1, 3'b000);
    show(3'd2, 3'b000, 9); gap(3'b000); idle(3'b000, 2);

    // simultaneous events resolve by priority
    tst = 2;
    cyc(3'b111, 1'b0, 3'd3, 1'b1, 1'b1, 3'b011);
`ifdef OVLY_PENDING_EN
    show(3'd3, 3'b011, 9); gap(3'b011); idle(3'b011, 1);
    show(3'd2, 3'b001, 10); gap(3'b001); idle(3'b001, 1);
    show(3'd1, 3'b000, 10); gap(3'b000); idle(3'b000, 2);
`else
    show(3'd3, 3'b000, 9); gap(3'b000); idle(3'b000, 3);
`endif

    // game_over preempts a level overlay, drops pending, ignores events
    tst = 3;
    cyc(3'b010, 1'b0, 3'd2, 1'b1, 1'b1, 3'b000);
    cyc(3'b001, 1'b0, 3'd2, 1'b1, 1'b1, 3'b001);
    show(3'd2, 3'b001, 2);
    nx_go = 1;
    cyc(3'b100, 1'b0, 3'd4, 1'b1, 1'b1, 3'b000);
    cyc(3'b001, 1'b0, 3'd4, 1'b1, 1'b1, 3'b000);
    cyc(3'b000, 1'b0, 3'd4, 1'b1, 1'b1, 3'b000);
    nx_go = 0;
    idle(3'b000, 4);

    // flash toggles every 2 frame_start pulses
    tst = 4;
    cyc(3'b100, 1'b0, 3'd3, 1'b1, 1'b1, 3'b000);
    fs_pat = 9'b101010101;
    fl_pat = 9'b111000011;
    for (int i = 0; i < 9; i++) cyc(3'b000, fs_pat[i], 3'd3, fl_pat[i], 1'b1, 3'b000);
    gap(3'b000); idle(3'b000, 2);

    // piece event gated by arcade mode
    tst = 5;
    nx_arc = 0;
    cyc(3'b001, 1'b0, 3'd0, 1'b0, 1'b0, 3'b000);
    idle(3'b000, 2);
    nx_arc = 1;
    cyc(3'b001, 1'b0, 3'd1, 1'b1, 1'b1, 3'b000);
    show(3'd1, 3'b000, 9); gap(3'b000); idle(3'b000, 2);

    // pending death re-armed by a pulse on its grant edge, then async reset mid-show
    tst = 6;
    cyc(3'b010, 1'b0, 3'd2, 1'b1, 1'b1, 3'b000);
    cyc(3'b100, 1'b0, 3'd2, 1'b1, 1'b1, 3'b100);
    show(3'd2, 3'b100, 8); gap(3'b100); idle(3'b100, 1);
    cyc(3'b100, 1'b0, 3'd3, 1'b1, 1'b1, 3'b100);
    show(3'd3, 3'b100, 3);
    areset();
    idle(3'b000, 2);
    nx_rst = 1;
    idle(3'b000, 4);

    // clr mid-show drops overlay and pending
    tst = 7;
    cyc(3'b010, 1'b0, 3'd2, 1'b1, 1'b1, 3'b000);
    show(3'd2, 3'b000, 2);
    cyc(3'b001, 1'b0, 3'd2, 1'b1, 1'b1, 3'b001);
    nx_clr = 1;
    cyc(3'b000, 1'b0, 3'd0, 1'b0, 1'b0, 3'b000);
    nx_clr = 0;
    idle(3'b000, 3);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 8, 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/overlay_sched.md
# overlay_sched

Sequences the full-screen overlay layers (piece bonus, level-up, death, game over) that the colour generators draw over the playfield. It latches one-cycle event pulses from game logic, grants one overlay at a time by fixed priority, and holds each for a programmable duration followed by a blank gap. It drives the overlay select and the flash phase consumed by the RGB overlay generators and the final pixel mux.

## Interface
- HOLD_CYCLES, 8000000: clk cycles an event overlay stays shown (≥1).
- GAP_CYCLES, 1000000: blank cycles after each event overlay (0 = no gap).
- FLASH_FRAMES, 8: frame_start pulses per flash half-period (≥1).
- clk  in  1  system pixel clock.
- reset  in  1  asynchronous, active-low reset.
- e_piece  in  1  one-cycle pulse: piece bonus event; ignored unless mode_arcade=1.
- e_level  in  1  one-cycle pulse: level complete.
- e_death  in  1  one-cycle pulse: player death.
- game_over  in  1  level: game over condition.
- clr  in  1  synchronous pulse: drop all pending events, return to IDLE.
- mode_arcade  in  1  level: arcade mode enable.
- frame_start  in  1  one-cycle pulse at start of each video frame.
- overlay_sel  out  3  0 none, 1 piece, 2 level, 3 death, 4 game over.
- flash_on  out  1  flash phase for the active overlay.
- busy  out  1  state ≠ IDLE.
- pending  out  3  {death, level, piece} latched requests.

## Operation
- States: IDLE, SHOW, GAP, GOVER. All outputs registered.
- Pending: event pulse sets its bit; bit clears on the edge its overlay is granted. A pulse on the grant edge of the same source re-sets the bit (not lost).
- Grant (IDLE only): request = pending | live pulses. Priority death > level > piece. Winner → SHOW, overlay_sel = its code, count = 0, flash_on = 1. Losers stay pending.
- SHOW: count increments each cycle; on count = HOLD_CYCLES-1 → GAP (count=0, overlay_sel=0, flash_on=0), or IDLE directly if GAP_CYCLES=0. Events during SHOW only set pending; no preemption among events.
- GAP: counts to GAP_CYCLES-1, then IDLE. IDLE grants on the following edge.
- Flash: in SHOW, a frame counter counts frame_start pulses; on reaching FLASH_FRAMES it toggles flash_on and reloads. Frame counter zeroed on SHOW entry.
- GOVER: game_over=1 preempts from any state on the next edge: overlay_sel=4, flash_on=1 constant, pending cleared, events ignored. game_over=0 → IDLE (no gap).
- clr: from IDLE/SHOW/GAP → IDLE, pending=0, outputs to reset values. In GOVER, clr only clears pending; game_over dominates.
- mode_arcade=0: e_piece ignored; a pending piece bit is cleared; an active piece SHOW completes normally.
- Counters 32-bit unsigned; no wrap inside legal parameter ranges.

## Timing
- Reset values: state IDLE, overlay_sel=0, flash_on=0, busy=0, pending=0, counters 0.
- Event pulse sampled at edge k in IDLE → overlay_sel valid after edge k (1-cycle latency).
- Event overlay visible exactly HOLD_CYCLES cycles; gap exactly GAP_CYCLES cycles; one IDLE cycle between consecutive overlays.
- game_over rise sampled at edge k → overlay_sel=4 after edge k, regardless of state.
- Reset assertion mid-SHOW: outputs return to reset values immediately (asynchronous).

## Configuration
- OVLY_PENDING_EN defined: pending latches as above.
- Not defined: no pending storage; pending output tied 0; events arriving while not IDLE are dropped; in IDLE simultaneous pulses still resolve by priority, losers dropped.

## Test plan
Use HOLD_CYCLES=10, GAP_CYCLES=3, FLASH_FRAMES=2.
- e_level pulse in IDLE at edge 5 -> overlay_sel=2 for edges 5..14, 0 for 3 gap cycles, busy low after that.
- e_piece, e_level, e_death same cycle -> overlay_sel sequence 3, 2, 1, each for 10 cycles, separated by 3 gap + 1 idle cycle; pending 3'b011 after first grant (PENDING_EN).
- game_over rises mid-SHOW of overlay 2 -> overlay_sel=4 next cycle, pending=0; game_over falls -> IDLE, overlay_sel=0.
- frame_start every 2 cycles during SHOW -> flash_on starts 1, toggles every 4 cycles.
- mode_arcade=0 with e_piece pulse -> no grant, pending stays 0; repeat with mode_arcade=1 -> overlay_sel=1.
- reset low mid-SHOW with pending=3'b100 -> all outputs 0 asynchronously; after release, no stale overlay granted.
